// File: rtl/spi_paint_ctrl.sv
// rtl/spi_paint_ctrl.sv - SPI paint command receiver with brush stamp / clear write sequencer
// Optional status readback on sdo: define SPI_STATUS_READBACK_EN.
module spi_paint_ctrl #(
  parameter int COORD_W  = 8,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int SIZE_MAX = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               sdi,
  input  logic               cs_n,
  output logic               sdo,
  output logic               we,
  output logic [COORD_W-1:0] wx,
  output logic [COORD_W-1:0] wy,
  output logic [2:0]         wcolor,
  output logic               busy,
  output logic               dropped
);

  localparam int PKT_W = 8 + 2 * COORD_W;
  localparam int CNT_W = $clog2(PKT_W + 1);
  localparam int SW    = COORD_W + 2;

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  state_t state, state_n;

  logic [1:0] sck_sy, sdi_sy, cs_sy;
  logic       sck_d;
  logic       sck_rise, cs_act, sdi_s;

  // Two-flop synchronisers for the SPI pins plus sck edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sy <= 2'b00;
      sdi_sy <= 2'b00;
      cs_sy  <= 2'b11;
      sck_d  <= 1'b0;
    end else begin
      sck_sy <= {sck_sy[0], sck};
      sdi_sy <= {sdi_sy[0], sdi};
      cs_sy  <= {cs_sy[0], cs_n};
      sck_d  <= sck_sy[1];
    end
  end

  assign sck_rise = sck_sy[1] & ~sck_d;
  assign cs_act   = ~cs_sy[1];
  assign sdi_s    = sdi_sy[1];

  logic [PKT_W-2:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [PKT_W-1:0] pkt_word;
  logic             shift_en, pkt_done, accept;

  assign shift_en = sck_rise & cs_act & (bit_cnt < CNT_W'(PKT_W));
  assign pkt_word = {shreg, sdi_s};
  assign pkt_done = shift_en & (bit_cnt == CNT_W'(PKT_W - 1));
  assign accept   = pkt_done & (state == IDLE);

  // Packet shifter; deasserted chip select discards any partial packet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (!cs_act) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= pkt_word[PKT_W-2:0];
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  logic [1:0]         opc;
  logic [2:0]         sz, col, side_eff, half;
  logic [COORD_W-1:0] x_in, y_in;

  assign opc  = pkt_word[PKT_W-1 -: 2];
  assign sz   = pkt_word[PKT_W-3 -: 3];
  assign col  = pkt_word[PKT_W-6 -: 3];
  assign x_in = pkt_word[2*COORD_W-1 -: COORD_W];
  assign y_in = pkt_word[COORD_W-1:0];

  // Clamp the requested brush side into 1..SIZE_MAX
  always_comb begin
    side_eff = sz;
    if (sz == 3'd0)
      side_eff = 3'd1;
    else if (sz > 3'(SIZE_MAX))
      side_eff = 3'(SIZE_MAX);
  end

  assign half = (side_eff - 3'd1) >> 1;

  logic [COORD_W-1:0] cnt_x, cnt_y, x_lim, y_lim;
  logic [SW-1:0]      org_x, org_y, pos_x, pos_y;
  logic [2:0]         side, color;
  logic               scan_last, in_x, in_y;

  assign x_lim     = (state == STAMP) ? COORD_W'(side - 3'd1) : COORD_W'(X_MAX);
  assign y_lim     = (state == STAMP) ? COORD_W'(side - 3'd1) : COORD_W'(Y_MAX);
  assign scan_last = (cnt_x == x_lim) && (cnt_y == y_lim);

  // Origin may go negative; two's complement in SW bits keeps the sign in the MSB
  assign pos_x = org_x + SW'(cnt_x);
  assign pos_y = org_y + SW'(cnt_y);
  assign in_x  = ~pos_x[SW-1] && (pos_x <= SW'(X_MAX));
  assign in_y  = ~pos_y[SW-1] && (pos_y <= SW'(Y_MAX));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic: packets are only taken while idle
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept && opc == 2'b01)      state_n = STAMP;
        else if (accept && opc == 2'b10) state_n = CLEAR;
      end
      STAMP, CLEAR: if (scan_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Scan counters and latched command fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_x <= '0;
      cnt_y <= '0;
      org_x <= '0;
      org_y <= '0;
      side  <= 3'd1;
      color <= 3'd0;
    end else if (accept) begin
      cnt_x <= '0;
      cnt_y <= '0;
      org_x <= SW'(x_in) - SW'(half);
      org_y <= SW'(y_in) - SW'(half);
      side  <= side_eff;
      color <= col;
    end else if (state != IDLE) begin
      if (cnt_x == x_lim) begin
        cnt_x <= '0;
        cnt_y <= cnt_y + 1'b1;
      end else begin
        cnt_x <= cnt_x + 1'b1;
      end
    end
  end

  logic [COORD_W-1:0] hold_x, hold_y;
  logic [2:0]         hold_c;

  // Output decode; idle keeps presenting the last write address and color
  always_comb begin
    we     = 1'b0;
    wx     = hold_x;
    wy     = hold_y;
    wcolor = hold_c;
    busy   = (state != IDLE);
    case (state)
      STAMP: begin
        we     = in_x & in_y;
        wx     = pos_x[COORD_W-1:0];
        wy     = pos_y[COORD_W-1:0];
        wcolor = color;
      end
      CLEAR: begin
        we     = 1'b1;
        wx     = cnt_x;
        wy     = cnt_y;
        wcolor = color;
      end
      default: ;
    endcase
  end

  // Remember presented write fields and flag packets that arrive while busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_x  <= '0;
      hold_y  <= '0;
      hold_c  <= 3'd0;
      dropped <= 1'b0;
    end else begin
      hold_x  <= wx;
      hold_y  <= wy;
      hold_c  <= wcolor;
      dropped <= pkt_done & (state != IDLE);
    end
  end

`ifdef SPI_STATUS_READBACK_EN
  logic       cs_d, drop_sticky, sck_fall, cs_fall;
  logic [1:0] last_opc;
  logic [7:0] stat_sh;

  assign sck_fall = ~sck_sy[1] & sck_d;
  assign cs_fall  = cs_d & ~cs_sy[1];

  // Status byte loaded at select, shifted out on sck falling edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_d        <= 1'b1;
      drop_sticky <= 1'b0;
      last_opc    <= 2'b00;
      stat_sh     <= 8'h00;
    end else begin
      cs_d <= cs_sy[1];
      if (accept) last_opc <= opc;
      if (cs_fall) begin
        stat_sh     <= {busy, drop_sticky, last_opc, 4'b0000};
        drop_sticky <= dropped;
      end else begin
        if (dropped) drop_sticky <= 1'b1;
        if (sck_fall && cs_act) stat_sh <= {stat_sh[6:0], 1'b0};
      end
    end
  end

  assign sdo = cs_act & stat_sh[7];
`else
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_paint_ctrl.sv
// tb/tb_spi_paint_ctrl.sv - randomized bench for spi_paint_ctrl against a write-list model
module tb_spi_paint_ctrl;
  localparam int CW = 8;
  localparam int XM = 159;
  localparam int YM = 119;
  localparam int SM = 5;

  logic          clk = 1'b0;
  logic          reset, sck, sdi, cs_n;
  logic          sdo, we, busy, dropped;
  logic [CW-1:0] wx, wy;
  logic [2:0]    wcolor;

  spi_paint_ctrl #(.COORD_W(CW), .X_MAX(XM), .Y_MAX(YM), .SIZE_MAX(SM)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
    .sdo(sdo), .we(we), .wx(wx), .wy(wy), .wcolor(wcolor),
    .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int exp_x[$], exp_y[$], exp_c[$], exp_len[$];
  int exp_drops = 0;
  int seen_drops = 0;
  int run_len = 0;
  bit prev_busy = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: list of writes and scan length an accepted packet must produce
  function automatic void model_packet(input int op, input int sz, input int col, input int x, input int y);
    int s, h, px, py;
    if (op == 1) begin
      s = (sz == 0) ? 1 : ((sz > SM) ? SM : sz);
      h = (s - 1) / 2;
      for (int r = 0; r < s; r++)
        for (int c = 0; c < s; c++) begin
          px = x - h + c;
          py = y - h + r;
          if (px >= 0 && px <= XM && py >= 0 && py <= YM) begin
            exp_x.push_back(px); exp_y.push_back(py); exp_c.push_back(col);
          end
        end
      exp_len.push_back(s * s);
    end else if (op == 2) begin
      for (int r = 0; r <= YM; r++)
        for (int c = 0; c <= XM; c++) begin
          exp_x.push_back(c); exp_y.push_back(r); exp_c.push_back(col);
        end
      exp_len.push_back((XM + 1) * (YM + 1));
    end
  endfunction

  function automatic logic [23:0] pkt(input int op, input int sz, input int col, input int x, input int y);
    logic [1:0] o; logic [2:0] s, c; logic [7:0] xx, yy;
    o = 2'(op); s = 3'(sz); c = 3'(col); xx = 8'(x); yy = 8'(y);
    return {o, s, c, xx, yy};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_send(input logic [23:0] w, input int nbits);
    cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      sdi = w[23 - i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
    tick(4);
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 30000) begin
      tick(1);
      n++;
    end
    chk("idle_wait", busy, 0);
    tick(3);
  endtask

  // Per-cycle comparison of DUT write port against the model
  always @(negedge clk) begin
    int ex, ey, ec, el;
    if (reset) begin
      prev_busy = 0;
      run_len = 0;
    end else begin
      if (we) begin
        if (exp_x.size() == 0) chk("unexpected_we", we, 0);
        else begin
          ex = exp_x.pop_front(); ey = exp_y.pop_front(); ec = exp_c.pop_front();
          chk("write_xyc", {wx, wy, wcolor}, {ex[7:0], ey[7:0], ec[2:0]});
        end
      end
      if (busy) run_len++;
      if (prev_busy && !busy) begin
        el = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
        chk("busy_len", run_len, el);
        run_len = 0;
      end
      prev_busy = busy;
      if (dropped) seen_drops++;
    end
  end

  initial begin
    int op, sz, col, x, y;
    reset = 1'b1; cs_n = 1'b1; sck = 1'b0; sdi = 1'b0;
    tick(3);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wxy", {wx, wy, wcolor}, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_sdo", sdo, 0);
    reset = 1'b0;
    tick(5);

    // 3x3 brush, pinned by hand
    model_packet(1, 3, 5, 10, 20);
    chk("pin_3x3_count", exp_x.size(), 9);
    chk("pin_3x3_first", exp_x[0] * 1000 + exp_y[0], 9019);
    chk("pin_3x3_last", exp_x[8] * 1000 + exp_y[8], 11021);
    spi_send(pkt(1, 3, 5, 10, 20), 24);
    wait_idle();

    // Corner clip
    model_packet(1, 5, 2, 0, 0);
    chk("pin_corner_count", exp_x.size(), 9);
    chk("pin_corner_len", exp_len[0], 25);
    spi_send(pkt(1, 5, 2, 0, 0), 24);
    wait_idle();

    // Size clamping
    model_packet(1, 0, 7, 40, 30);
    chk("pin_size0_count", exp_x.size(), 1);
    spi_send(pkt(1, 0, 7, 40, 30), 24);
    wait_idle();
    model_packet(1, 7, 3, 50, 50);
    chk("pin_size7_len", exp_len[0], 25);
    spi_send(pkt(1, 7, 3, 50, 50), 24);
    wait_idle();

    // Partial packet then NOP: nothing happens
    spi_send(pkt(1, 3, 1, 60, 60), 13);
    spi_send(pkt(0, 3, 1, 60, 60), 24);
    wait_idle();
    chk("nop_no_drop", seen_drops, exp_drops);
    chk("nop_no_writes", exp_x.size(), 0);

    // Clear with a PAINT arriving mid-clear
    model_packet(2, 0, 0, 0, 0);
    spi_send(pkt(2, 0, 0, 0, 0), 24);
    chk("busy_in_clear", busy, 1);
    spi_send(pkt(1, 3, 6, 5, 5), 24);
    chk("sdo_tied", sdo, 0);
    exp_drops++;
    wait_idle();
    chk("clear_drops", seen_drops, exp_drops);
    chk("clear_all_written", exp_x.size(), 0);

    // Random PAINT / NOP / reserved packets
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if (op == 2) op = 1;
      sz = $urandom_range(0, 7); col = $urandom_range(0, 7);
      x = $urandom_range(0, 255); y = $urandom_range(0, 255);
      model_packet(op, sz, col, x, y);
      spi_send(pkt(op, sz, col, x, y), 24);
      wait_idle();
    end
    chk("rand_all_written", exp_x.size(), 0);
    chk("rand_all_scans", exp_len.size(), 0);

    // Reset mid-clear aborts with no further writes
    model_packet(2, 4, 0, 0, 0);
    spi_send(pkt(2, 4, 0, 0, 0), 24);
    tick(100);
    reset = 1'b1;
    #1;
    chk("abort_we", we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wxy", {wx, wy, wcolor}, 0);
    exp_x.delete(); exp_y.delete(); exp_c.delete(); exp_len.delete();
    tick(3);
    reset = 1'b0;
    tick(50);
    chk("after_abort_busy", busy, 0);
    chk("after_abort_we", we, 0);
    chk("final_drops", seen_drops, exp_drops);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/spi_paint_ctrl.md
Name: spi_paint_ctrl

Overview:
- Parametrised successor to the board's SPI-to-framebuffer path: a clk-domain SPI slave receiver, a packet decoder and a brush write sequencer.
- Receives fixed-length paint commands from the MCU.
- Drives the framebuffer write port: square brush stamps with edge clipping, or a full-screen clear.
- Sits between the SPI pins and the pixel store write port; pixel store and VGA read path are unchanged.

Parameters:
- COORD_W, 8, width of x/y coordinates and of the wx/wy outputs.
- X_MAX, 159, largest valid x (inclusive); must be < 2^COORD_W.
- Y_MAX, 119, largest valid y (inclusive); must be < 2^COORD_W.
- SIZE_MAX, 5, largest brush side in pixels; range 1..7.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sck  input  1  SPI clock from MCU; mode 0; asynchronous to clk.
- sdi  input  1  SPI data in, MSB first.
- cs_n  input  1  SPI chip select, active low.
- sdo  output  1  SPI data out (see Optional Feature).
- we  output  1  framebuffer write enable.
- wx  output  COORD_W  write x.
- wy  output  COORD_W  write y.
- wcolor  output  3  write color code.
- busy  output  1  sequencer not IDLE.
- dropped  output  1  one-cycle pulse: a complete packet was discarded.

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock.
  - All outputs 0; state IDLE; bit counter 0.
  - Reset mid-stamp or mid-clear aborts immediately; no further writes.
- Input sync: sck, sdi and cs_n each pass through 2 flip-flop synchronisers. A rising edge of sck is detected from the synchronised sck versus its previous value.
- Shift register: PKT_W = 8 + 2*COORD_W bits.
  - Synchronised cs_n high clears the bit counter; a partial packet is discarded silently.
  - On each detected sck rise with cs_n low, sdi shifts in and the counter increments.
  - Bits beyond PKT_W in the same cs_n window are ignored.
- Packet layout, MSB first:
  - [PKT_W-1:PKT_W-2] opcode: 00 NOP, 01 PAINT, 10 CLEAR, 11 reserved (treated as NOP).
  - [PKT_W-3:PKT_W-5] size.
  - [PKT_W-6:PKT_W-8] color.
  - then x (COORD_W bits), then y (COORD_W bits).
- Packet complete: asserts on the cycle the PKT_W-th bit is captured.
  - State IDLE: packet is accepted.
  - Otherwise: dropped pulses for 1 cycle and the packet is discarded.
- FSM states: IDLE, STAMP, CLEAR.
  - IDLE -> STAMP: accepted PAINT.
  - IDLE -> CLEAR: accepted CLEAR.
  - NOP and reserved opcodes: stay in IDLE.
- STAMP:
  - Effective side s = max(1, min(size, SIZE_MAX)).
  - Origin ox = x - (s-1)/2, oy = y - (s-1)/2, computed signed in COORD_W+2 bits (integer division).
  - Scans s*s positions, row-major (x inner, y outer), one position per cycle.
  - First position is presented the cycle after acceptance.
  - A position with 0 <= px <= X_MAX and 0 <= py <= Y_MAX drives we=1, wx=px, wy=py, wcolor=color.
  - An out-of-range position drives we=0 and still consumes the cycle. Latency is exactly s*s cycles, then the FSM returns to IDLE.
  - busy is high from the cycle after acceptance through the last scan cycle.
- CLEAR:
  - Writes every pixel (0,0)..(X_MAX,Y_MAX), row-major, one per cycle, we=1, wcolor=color.
  - Takes (X_MAX+1)*(Y_MAX+1) cycles, then returns to IDLE.
- IDLE: we=0. wx, wy and wcolor hold their last values.
- A packet completing on the same cycle the FSM leaves STAMP or CLEAR is dropped; acceptance requires IDLE at the sampling edge.

Optional Feature:
- Macro: SPI_STATUS_READBACK_EN.
- When defined:
  - A status byte {busy, drop_sticky, last_opcode[1:0], 4'b0} is loaded at the synchronised cs_n falling edge.
  - It is shifted out MSB first, advancing on each detected sck falling edge.
  - drop_sticky is set by dropped and cleared when the status byte is loaded.
  - sdo=0 after 8 bits and while cs_n is high.
- When undefined: sdo is tied to 0 and no status logic exists.

Test Plan:
- Reset asserted mid-CLEAR, then released: we=0 immediately and stays 0; busy=0; state IDLE; no writes resume.
- PAINT size=3, color=5, x=10, y=20: exactly 9 writes, covering (9..11, 19..21) row-major, wcolor=5; busy high exactly 9 cycles.
- PAINT size=5, x=0, y=0: 25 scan cycles; only 9 writes, at (0..2, 0..2); no write with negative or wrapped coordinates.
- PAINT size=0 and size=7 with SIZE_MAX=5: 1 write at (x,y), and 25 scan cycles, respectively.
- CLEAR color=0 followed by a PAINT packet during the clear: 19200 writes covering every pixel once; PAINT dropped with one dropped pulse; busy low after the last write.
- cs_n raised after 13 bits, then a valid NOP packet: no writes, no dropped pulse. With SPI_STATUS_READBACK_EN, after a drop the next readback shows bit6=1 and the following readback shows bit6=0.
